// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
`default_nettype none

package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor built from two half-subtractor stages.
`default_nettype none

module full_sub (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  // First stage subtracts y from x, second stage subtracts the incoming borrow.
  assign d1   = x ^ y;
  assign b1   = ~x & y;
  assign d    = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial subtractor: one result bit per clock, registered borrow.
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             bit_d;
  logic             bit_bout;
  logic             last_bit;

  full_sub u_full_sub (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (brw),
    .d    (bit_d),
    .bout (bit_bout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state == RUN);
      done  <= (next_state == DONE);
      if (state == IDLE && start) begin
        a_sh <= a;
        b_sh <= b;
        brw  <= 1'b0;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        res  <= {bit_d, res[WIDTH-1:1]};
        brw  <= bit_bout;
        cnt  <= cnt + CW'(1);
      end
    end
  end

  assign diff   = res;
  assign borrow = brw;

endmodule

`default_nettype wire
